// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back path.
// Holds the address/data typedefs, the arbiter grant encoding and the busy-mask helper.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

  typedef enum logic {
    GRANT_REQ0 = 1'b0,
    GRANT_REQ1 = 1'b1
  } grant_e;

  // One-hot mask for a busy-bitmap update; register 0 never produces a bit.
  function automatic logic [NUM_REGS-1:0] addrMask(input reg_addr_t addr, input logic en);
    logic [NUM_REGS-1:0] mask;
    mask = '0;
    if (en && (addr != ZERO_REG)) begin
      mask[addr] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the pipeline (master) and the write-back arbiter (slave).
// Carries both write-back requesters, the decode reservation/lookup and the regfile write port.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic      req0_valid;
  logic      req0_ready;
  reg_addr_t req0_addr;
  reg_data_t req0_data;

  logic      req1_valid;
  logic      req1_ready;
  reg_addr_t req1_addr;
  reg_data_t req1_data;

  logic      rsv_valid;
  reg_addr_t rsv_addr;

  reg_addr_t rd_addr1;
  reg_addr_t rd_addr2;
  logic      rd_busy1;
  logic      rd_busy2;

  logic      rf_w;
  reg_addr_t rf_wa;
  reg_data_t rf_wd;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output rsv_valid, rsv_addr, rd_addr1, rd_addr2,
    input  req0_ready, req1_ready, rd_busy1, rd_busy2,
    input  rf_w, rf_wa, rf_wd
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  rsv_valid, rsv_addr, rd_addr1, rd_addr2,
    output req0_ready, req1_ready, rd_busy1, rd_busy2,
    output rf_w, rf_wa, rf_wd
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy bitmap of register destinations reserved at decode and not yet committed.
// A reservation landing on the same edge as a commit to that register keeps it busy.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_setValid,
  input  reg_addr_t i_setAddr,
  input  logic      i_clrValid,
  input  reg_addr_t i_clrAddr,
  input  reg_addr_t i_lookupAddr1,
  input  reg_addr_t i_lookupAddr2,
  output logic      o_busy1,
  output logic      o_busy2
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_setMask;
  logic [NUM_REGS-1:0] w_clrMask;
  logic [NUM_REGS-1:0] w_busyNext;

  // Set is OR'd in after the clear so a fresh reservation outranks the commit.
  assign w_setMask  = addrMask(i_setAddr, i_setValid);
  assign w_clrMask  = addrMask(i_clrAddr, i_clrValid);
  assign w_busyNext = (r_busy & ~w_clrMask) | w_setMask;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busyNext;
    end
  end

  assign o_busy1 = r_busy[i_lookupAddr1] & (i_lookupAddr1 != ZERO_REG);
  assign o_busy2 = r_busy[i_lookupAddr2] & (i_lookupAddr2 != ZERO_REG);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter sharing the single register-file write port
// between the ALU (req0) and load (req1) paths, plus the decode hazard scoreboard.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  regfile_wb_arbiter_if.slave bus
);

  grant_e    r_lastGrant;
  logic      r_rfW;
  reg_addr_t r_rfWa;
  reg_data_t r_rfWd;

  logic      w_grant0;
  logic      w_grant1;
  logic      w_accept;
  reg_addr_t w_accAddr;
  reg_data_t w_accData;
  logic      w_rfW;

  // Under contention the requester that did not win last time goes next.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (rst_n) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (r_lastGrant == GRANT_REQ1) begin
          w_grant0 = 1'b1;
        end else begin
          w_grant1 = 1'b1;
        end
      end else begin
        w_grant0 = bus.req0_valid;
        w_grant1 = bus.req1_valid;
      end
    end
  end

  always_comb begin
    w_accept  = w_grant0 | w_grant1;
    w_accAddr = bus.req0_addr;
    w_accData = bus.req0_data;
    if (w_grant1) begin
      w_accAddr = bus.req1_addr;
      w_accData = bus.req1_data;
    end
  end

  // Accepted request is issued to the regfile one cycle later; register 0 writes are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rfW       <= 1'b0;
      r_rfWa      <= ZERO_REG;
      r_rfWd      <= '0;
      r_lastGrant <= GRANT_REQ1;
    end else begin
      r_rfW <= w_accept && (w_accAddr != ZERO_REG);
      if (w_accept) begin
        r_rfWa      <= w_accAddr;
        r_rfWd      <= w_accData;
        r_lastGrant <= w_grant1 ? GRANT_REQ1 : GRANT_REQ0;
      end
    end
  end

  // Gating by rst_n stops a write already issued from committing during reset.
  assign w_rfW = r_rfW & rst_n;

  regfile_scoreboard u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_setValid   (bus.rsv_valid),
    .i_setAddr    (bus.rsv_addr),
    .i_clrValid   (w_rfW),
    .i_clrAddr    (r_rfWa),
    .i_lookupAddr1(bus.rd_addr1),
    .i_lookupAddr2(bus.rd_addr2),
    .o_busy1      (bus.rd_busy1),
    .o_busy2      (bus.rd_busy2)
  );

  assign bus.req0_ready = w_grant0;
  assign bus.req1_ready = w_grant1;
  assign bus.rf_w       = w_rfW;
  assign bus.rf_wa      = r_rfWa;
  assign bus.rf_wd      = r_rfWd;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for the write-back arbiter with an expected-write queue
// and a behavioural register file that commits on rf_w.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  typedef struct {
    logic      w;
    reg_addr_t wa;
    reg_data_t wd;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t expQ[$];
  reg_data_t rfModel [NUM_REGS];

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the real register file: commits at the edge where rf_w is high.
  always @(posedge clk) begin
    if (bus.rf_w) rfModel[bus.rf_wa] <= bus.rf_wd;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input reg_addr_t a0, input reg_data_t d0,
                               input logic v1, input reg_addr_t a1, input reg_data_t d1,
                               input logic rv, input reg_addr_t ra);
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    bus.req1_data  = d1;
    bus.rsv_valid  = rv;
    bus.rsv_addr   = ra;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic expectWrite(input logic w, input reg_addr_t wa, input reg_data_t wd);
    exp_t e;
    e.w  = w;
    e.wa = wa;
    e.wd = wd;
    expQ.push_back(e);
  endtask

  // Advance one clock and compare the write port against the oldest expectation.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("rf_w", {31'd0, bus.rf_w}, {31'd0, e.w});
      if (e.w) begin
        checkOutput("rf_wa", {27'd0, bus.rf_wa}, {27'd0, e.wa});
        checkOutput("rf_wd", bus.rf_wd, e.wd);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.rd_addr1 = 5'd5;
    bus.rd_addr2 = 5'd0;
    applyStimulus(1'b1, 5'd15, 32'd1234, 1'b1, 5'd3, 32'd9, 1'b1, 5'd5);
    checkOutput("reset_ready0", {31'd0, bus.req0_ready}, 32'd0);
    checkOutput("reset_ready1", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("reset_rf_w", {31'd0, bus.rf_w}, 32'd0);
    checkOutput("reset_rf_wa", {27'd0, bus.rf_wa}, 32'd0);
    checkOutput("reset_rf_wd", bus.rf_wd, 32'd0);
    checkOutput("reset_busy5", {31'd0, bus.rd_busy1}, 32'd0);
    rst_n = 1'b1;
    idle();

    $display("[TB] contention");
    applyStimulus(1'b1, 5'd30, 32'd56781, 1'b1, 5'd15, 32'd99, 1'b0, 5'd0);
    checkOutput("cont1_ready0", {31'd0, bus.req0_ready}, 32'd1);
    checkOutput("cont1_ready1", {31'd0, bus.req1_ready}, 32'd0);
    expectWrite(1'b1, 5'd30, 32'd56781);
    tick();
    checkOutput("cont2_ready0", {31'd0, bus.req0_ready}, 32'd0);
    checkOutput("cont2_ready1", {31'd0, bus.req1_ready}, 32'd1);
    expectWrite(1'b1, 5'd15, 32'd99);
    tick();
    checkOutput("cont3_ready0", {31'd0, bus.req0_ready}, 32'd1);
    expectWrite(1'b1, 5'd30, 32'd56781);
    tick();
    idle();
    expectWrite(1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("rf_r30", rfModel[30], 32'd56781);
    checkOutput("rf_r15", rfModel[15], 32'd99);

    $display("[TB] single write");
    applyStimulus(1'b1, 5'd15, 32'd1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    checkOutput("single_ready0", {31'd0, bus.req0_ready}, 32'd1);
    expectWrite(1'b1, 5'd15, 32'd1234);
    tick();
    idle();
    expectWrite(1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("single_r15", rfModel[15], 32'd1234);
    checkOutput("hold_rf_wa", {27'd0, bus.rf_wa}, 32'd15);
    checkOutput("hold_rf_wd", bus.rf_wd, 32'd1234);

    $display("[TB] zero register");
    bus.rd_addr1 = 5'd0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd77, 1'b1, 5'd0);
    checkOutput("zero_ready1", {31'd0, bus.req1_ready}, 32'd1);
    expectWrite(1'b0, 5'd0, 32'd0);
    tick();
    idle();
    checkOutput("zero_busy", {31'd0, bus.rd_busy1}, 32'd0);

    $display("[TB] scoreboard");
    bus.rd_addr1 = 5'd30;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd30);
    checkOutput("sb_before_rsv", {31'd0, bus.rd_busy1}, 32'd0);
    expectWrite(1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("sb_after_rsv", {31'd0, bus.rd_busy1}, 32'd1);
    applyStimulus(1'b1, 5'd30, 32'd42, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    expectWrite(1'b1, 5'd30, 32'd42);
    tick();
    idle();
    checkOutput("sb_commit_cycle", {31'd0, bus.rd_busy1}, 32'd1);
    expectWrite(1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("sb_after_commit", {31'd0, bus.rd_busy1}, 32'd0);
    checkOutput("sb_r30", rfModel[30], 32'd42);

    $display("[TB] simultaneous set and clear");
    bus.rd_addr2 = 5'd15;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd15);
    expectWrite(1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 32'd555, 1'b0, 5'd0);
    checkOutput("sim_ready1", {31'd0, bus.req1_ready}, 32'd1);
    expectWrite(1'b1, 5'd15, 32'd555);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd15);
    checkOutput("sim_busy_pre", {31'd0, bus.rd_busy2}, 32'd1);
    expectWrite(1'b0, 5'd0, 32'd0);
    tick();
    idle();
    checkOutput("sim_busy_set_wins", {31'd0, bus.rd_busy2}, 32'd1);
    checkOutput("sim_r15", rfModel[15], 32'd555);
    applyStimulus(1'b1, 5'd15, 32'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    expectWrite(1'b1, 5'd15, 32'd7);
    tick();
    idle();
    expectWrite(1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("sim_busy_cleared", {31'd0, bus.rd_busy2}, 32'd0);

    $display("[TB] reset mid-write");
    bus.rd_addr1 = 5'd20;
    applyStimulus(1'b1, 5'd15, 32'd1234, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20);
    checkOutput("mid_ready0", {31'd0, bus.req0_ready}, 32'd1);
    expectWrite(1'b1, 5'd15, 32'd1234);
    tick();
    checkOutput("mid_busy20", {31'd0, bus.rd_busy1}, 32'd1);
    rst_n = 1'b0;
    applyStimulus(1'b1, 5'd15, 32'd1234, 1'b1, 5'd3, 32'd9, 1'b1, 5'd20);
    checkOutput("mid_rf_w_gated", {31'd0, bus.rf_w}, 32'd0);
    checkOutput("mid_ready0_rst", {31'd0, bus.req0_ready}, 32'd0);
    checkOutput("mid_ready1_rst", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("mid_rf_w_after", {31'd0, bus.rf_w}, 32'd0);
    checkOutput("mid_no_write_r15", rfModel[15], 32'd7);
    checkOutput("mid_busy20_clr", {31'd0, bus.rd_busy1}, 32'd0);
    checkOutput("mid_busy15_clr", {31'd0, bus.rd_busy2}, 32'd0);
    rst_n = 1'b1;
    idle();
    expectWrite(1'b0, 5'd0, 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-back controller for the 32x32 two-read/one-write register file. It shares the single write port (w, wa, wd) between two writers, the ALU result path (req0) and the memory-load path (req1), using valid/ready handshakes and round-robin arbitration. It also keeps a busy-bit scoreboard of destinations reserved at decode, so the decode stage can detect read-after-write hazards on both read addresses.

Parameters:
ADDR_W, 5, register address width
DATA_W, 32, register data width
NUM_REGS, 32, number of architectural registers (2**ADDR_W)

Ports:
clk  in  1  system clock, all state updates on posedge
rst_n  in  1  synchronous active-low reset
req0_valid  in  1  ALU write-back request
req0_ready  out  1  req0 accepted this cycle
req0_addr  in  ADDR_W  ALU destination register
req0_data  in  DATA_W  ALU result
req1_valid  in  1  load write-back request
req1_ready  out  1  req1 accepted this cycle
req1_addr  in  ADDR_W  load destination register
req1_data  in  DATA_W  load data
rsv_valid  in  1  decode reserves a destination
rsv_addr  in  ADDR_W  register being reserved
rd_addr1  in  ADDR_W  decode read address 1 (same as regfile i1)
rd_addr2  in  ADDR_W  decode read address 2 (same as regfile i2)
rd_busy1  out  1  rd_addr1 has a pending write
rd_busy2  out  1  rd_addr2 has a pending write
rf_w  out  1  register-file write enable
rf_wa  out  ADDR_W  register-file write address
rf_wd  out  DATA_W  register-file write data

Behaviour:
- Reset (rst_n=0 at posedge):
  - rf_w=0, rf_wa=0, rf_wd=0, busy[31:0]=0, last_grant=1 (so req0 wins first contention).
  - req0_ready and req1_ready are forced 0 combinationally while rst_n=0.
  - An in-flight handshake or reservation in the reset cycle is discarded. Reset mid-write cancels the pending rf_w.
- Arbitration (combinational):
  - Only one requester valid: it gets ready=1.
  - Both valid: grant the requester not equal to last_grant.
  - last_grant updates only on an accepted handshake (valid&ready).
  - ready never depends on the other requester's data.
- Write issue (1-cycle latency): a handshake at edge N drives rf_w=1, rf_wa=addr, rf_wd=data for exactly the cycle after edge N. The register file commits at edge N+1.
  - No handshake at edge N gives rf_w=0; rf_wa and rf_wd hold their previous values.
  - Back-to-back accepts give a write every cycle, so throughput is 1 write/cycle.
- Register 0:
  - A request with addr=0 is handshaken normally but issues rf_w=0 (write suppressed).
  - busy[0] is never set; rd_busy is 0 for address 0.
- Scoreboard:
  - busy[rsv_addr] is set at the edge where rsv_valid=1 and rsv_addr!=0.
  - busy[rf_wa] is cleared at the edge where rf_w=1, i.e. the same edge the register file commits.
  - Set and clear of the same address at the same edge: set wins (a newer reservation is outstanding).
  - Writes to a non-busy register are legal and leave busy unchanged.
  - Re-reserving an already-busy register keeps it busy; there is no counting, and the first commit clears it.
- Hazard outputs (combinational): rd_busyK = busy[rd_addrK] & (rd_addrK!=0). There is no bypass: a reader sees busy=1 up to and including the commit cycle, and busy=0 from the cycle after commit, when the register file read returns new data.

Decomposition:
- Shared package regfile_pkg:
  - constants ADDR_W=5, DATA_W=32, NUM_REGS=32, ZERO_REG=5'd0
  - typedefs for reg address and reg data
- One natural sub-module, regfile_scoreboard: the busy bitmap with set/clear/priority logic and two combinational lookup ports. Arbitration and the output register stay in the top.

Test Plan:
- Single write: req0 (addr 15, data 1234) alone -> req0_ready=1; next cycle rf_w=1, rf_wa=15, rf_wd=1234. Regfile read of i1=15 returns 1234 after that edge.
- Contention: req0 (30, 56781) and req1 (15, 99) both held valid for 3 cycles after reset -> grants req0, req1, req0. rf_wa sequence is 30, 15, 30 on consecutive cycles.
- Zero register: req1 (addr 0, data 77) -> req1_ready=1, rf_w stays 0. rd_busy1 with rd_addr1=0 is 0 even after rsv_valid with rsv_addr=0.
- Scoreboard: rsv 30 at edge A -> rd_busy1(rd_addr1=30)=1 from cycle A+1. A req0 write to 30 keeps busy=1 through the rf_w cycle, then busy=0 the cycle after commit.
- Simultaneous: commit to 15 on the same edge as rsv_valid with rsv_addr=15 -> rd_busy2(rd_addr2=15) stays 1.
- Reset mid-operation: assert rst_n=0 the cycle after req0 (15, 1234) is accepted -> rf_w=0 after that edge, no write reaches r15, busy all 0, both ready=0 during reset.
